// File: rtl/mux2_read_sched_pkg.sv
// Shared scheduler definitions for the dual-bank radix-16 operand path.
// The state encodings and the latency default are reused by the write-side scheduler.
package mux2_read_sched_pkg;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_READ    = 2'd1;
   localparam logic [1:0] ST_WAIT_WB = 2'd2;
   localparam logic [1:0] ST_DONE    = 2'd3;

   localparam int MEM_LAT_DEF = 1;

   typedef struct packed {
      logic valid;
      logic sel;
   } sel_valid_t;

endpackage

// File: rtl/mux2_read_sched_sel_valid_delay.sv
// Fixed-depth delay line for a {valid, sel} pair.
// Each stage keeps its sel on bubbles, so the output sel holds the last valid one.
module sel_valid_delay
   import mux2_read_sched_pkg::*;
#(
   parameter int DEPTH = MEM_LAT_DEF
) (
   input  logic       clk,
   input  logic       rst,
   input  sel_valid_t d,
   output sel_valid_t q
);

   sel_valid_t [DEPTH-1:0] pipe;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pipe <= '0;
      end else begin
         pipe[0].valid <= d.valid;
         if (d.valid) begin
            pipe[0].sel <= d.sel;
         end
         for (int i = 1; i < DEPTH; i++) begin
            pipe[i].valid <= pipe[i-1].valid;
            if (pipe[i-1].valid) begin
               pipe[i].sel <= pipe[i-1].sel;
            end
         end
      end
   end

   assign q = pipe[DEPTH-1];

endmodule

// File: rtl/mux2_read_sched.sv
// Read-side scheduler: issues group reads stage by stage from one bank,
// ping-ponging banks between stages once write-back is acknowledged.
module mux2_read_sched
   import mux2_read_sched_pkg::*;
#(
   parameter int ADDR_WIDTH  = 6,
   parameter int GROUP_NUM   = 64,
   parameter int STAGE_NUM   = 3,
   parameter int STAGE_WIDTH = 2,
   parameter int MEM_LAT     = MEM_LAT_DEF
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic                   init_bank,
   input  logic                   stall,
   input  logic                   wb_done,
   output logic                   rd_en,
   output logic [ADDR_WIDTH-1:0]  rd_addr,
   output logic                   BN_sel,
   output logic                   ra_valid,
   output logic [STAGE_WIDTH-1:0] stage_cnt,
   output logic                   busy,
   output logic                   done
);

   localparam logic [ADDR_WIDTH-1:0]  LAST_ADDR  = ADDR_WIDTH'(GROUP_NUM - 1);
   localparam logic [STAGE_WIDTH-1:0] LAST_STAGE = STAGE_WIDTH'(STAGE_NUM - 1);

   logic [1:0]             state;
   logic [ADDR_WIDTH-1:0]  addr;
   logic [ADDR_WIDTH-1:0]  last_addr;
   logic [STAGE_WIDTH-1:0] stage;
   logic                   bank;
   logic                   issue;
   sel_valid_t             dly_in;
   sel_valid_t             dly_out;

   assign issue = (state == ST_READ) && !stall;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ST_IDLE;
         addr      <= '0;
         last_addr <= '0;
         stage     <= '0;
         bank      <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  bank  <= init_bank;
                  stage <= '0;
                  addr  <= '0;
                  state <= ST_READ;
               end
            end
            ST_READ: begin
               if (!stall) begin
                  last_addr <= addr;
                  if (addr == LAST_ADDR) begin
                     addr  <= '0;
                     state <= ST_WAIT_WB;
                  end else begin
                     addr <= addr + 1'b1;
                  end
               end
            end
            ST_WAIT_WB: begin
               if (wb_done) begin
                  if (stage == LAST_STAGE) begin
                     state <= ST_DONE;
                  end else begin
                     stage <= stage + 1'b1;
                     bank  <= ~bank;
                     state <= ST_READ;
                  end
               end
            end
            default: begin
               state <= ST_IDLE;
            end
         endcase
      end
   end

   // Stalled or idle cycles replay the previous address on the bus.
   assign rd_en   = issue;
   assign rd_addr = issue ? addr : last_addr;

   assign dly_in.valid = issue;
   assign dly_in.sel   = bank;

   sel_valid_delay #(
      .DEPTH (MEM_LAT)
   ) u_dly (
      .clk (clk),
      .rst (rst),
      .d   (dly_in),
      .q   (dly_out)
   );

   assign ra_valid  = dly_out.valid;
   assign BN_sel    = dly_out.sel;
   assign stage_cnt = stage;
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_DONE);

endmodule

// File: tb/tb_mux2_read_sched.sv
// Randomized and directed bench for mux2_read_sched.
// A transaction-count reference model predicts every output each cycle.
module tb_mux2_read_sched;

   localparam int AW = 6;
   localparam int G  = 4;
   localparam int SN = 2;
   localparam int SW = 2;
   localparam int ML = 1;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic          init_bank = 1'b0;
   logic          stall = 1'b0;
   logic          wb_done = 1'b0;
   logic          rd_en;
   logic [AW-1:0] rd_addr;
   logic          BN_sel;
   logic          ra_valid;
   logic [SW-1:0] stage_cnt;
   logic          busy;
   logic          done;

   mux2_read_sched #(
      .ADDR_WIDTH  (AW),
      .GROUP_NUM   (G),
      .STAGE_NUM   (SN),
      .STAGE_WIDTH (SW),
      .MEM_LAT     (ML)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .init_bank (init_bank),
      .stall     (stall),
      .wb_done   (wb_done),
      .rd_en     (rd_en),
      .rd_addr   (rd_addr),
      .BN_sel    (BN_sel),
      .ra_valid  (ra_valid),
      .stage_cnt (stage_cnt),
      .busy      (busy),
      .done      (done)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string tag, input int unsigned got,
                      input int unsigned exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
      end
   endtask

   // Model: a transform is busy, has issued m_issued groups of the
   // current stage and either still reads, waits, or is finishing.
   bit m_busy, m_fin, m_bank, m_bn;
   int m_issued, m_stage, m_last, m_beats;
   bit hv[ML];
   bit hb[ML];

   function automatic void m_reset();
      m_busy = 0; m_fin = 0; m_bank = 0; m_bn = 0;
      m_issued = 0; m_stage = 0; m_last = 0; m_beats = 0;
      for (int i = 0; i < ML; i++) begin
         hv[i] = 0;
         hb[i] = 0;
      end
   endfunction

   function automatic bit m_reading();
      return m_busy && !m_fin && (m_issued < G);
   endfunction

   function automatic bit m_en();
      return m_reading() && !stall;
   endfunction

   task automatic check_outputs(input bit count_beats);
      bit e;
      e = m_en();
      chk("rd_en", rd_en, e);
      chk("rd_addr", rd_addr, e ? m_issued : m_last);
      chk("ra_valid", ra_valid, hv[ML-1]);
      chk("BN_sel", BN_sel, m_bn);
      chk("stage_cnt", stage_cnt, m_stage);
      chk("busy", busy, m_busy);
      chk("done", done, m_fin);
      if (count_beats) begin
         if (ra_valid === 1'b1) m_beats++;
         if (m_fin) chk("beats", m_beats, G * SN);
      end
   endtask

   task automatic m_step();
      bit e;
      e = m_en();
      for (int i = ML - 1; i > 0; i--) begin
         hv[i] = hv[i-1];
         hb[i] = hb[i-1];
      end
      hv[0] = e;
      hb[0] = m_bank;
      if (hv[ML-1]) m_bn = hb[ML-1];
      if (!m_busy) begin
         if (start) begin
            m_busy = 1; m_bank = init_bank;
            m_stage = 0; m_issued = 0; m_beats = 0;
         end
      end else if (m_fin) begin
         m_busy = 0;
         m_fin = 0;
      end else if (m_issued < G) begin
         if (!stall) begin
            m_last = m_issued;
            m_issued++;
         end
      end else if (wb_done) begin
         if (m_stage == SN - 1) begin
            m_fin = 1;
         end else begin
            m_stage++;
            m_bank = !m_bank;
            m_issued = 0;
         end
      end
   endtask

   // Called just after a rising edge; covers one full clock cycle.
   task automatic step(input bit s, input bit ib, input bit st,
                       input bit wb);
      start = s; init_bank = ib; stall = st; wb_done = wb;
      @(negedge clk);
      check_outputs(1);
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0);
   endtask

   task automatic do_reset(input bit xin);
      if (xin) begin
         start = 1'bx; init_bank = 1'bx; stall = 1'bx; wb_done = 1'bx;
      end
      rst = 1'b1;
      #1;
      m_reset();
      chk("rst_rd_en", rd_en, 0);
      chk("rst_rd_addr", rd_addr, 0);
      chk("rst_ra_valid", ra_valid, 0);
      chk("rst_BN_sel", BN_sel, 0);
      chk("rst_stage", stage_cnt, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      start = 0; init_bank = 0; stall = 0; wb_done = 0;
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      m_step();
      #1;
   endtask

   initial begin
      m_reset();
      #3;
      do_reset(1);
      idle(3);

      // nominal two-stage transform
      step(1, 0, 0, 0);
      idle(7);
      step(0, 0, 0, 1);
      idle(7);
      step(0, 0, 0, 1);
      idle(3);

      // 3-cycle stall with addr 2 next
      step(1, 0, 0, 0);
      idle(2);
      repeat (3) step(0, 0, 1, 0);
      idle(4);
      step(0, 0, 0, 1);
      idle(6);
      step(0, 0, 0, 1);
      idle(3);

      // start and wb_done during READ are ignored
      step(1, 1, 0, 0);
      step(0, 0, 0, 0);
      step(1, 0, 0, 0);
      step(0, 0, 0, 1);
      idle(3);
      step(0, 0, 0, 1);
      idle(6);
      step(1, 0, 0, 1);
      idle(3);

      // reset mid-READ of stage 1 with addr 1 next
      step(1, 0, 0, 0);
      idle(5);
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
      do_reset(0);
      step(1, 1, 0, 0);
      idle(6);
      step(0, 0, 0, 1);
      idle(6);
      step(0, 0, 0, 1);
      idle(3);

      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(599) == 0) begin
            do_reset(0);
         end else begin
            step($urandom_range(7) == 0, 1'($urandom),
                 $urandom_range(3) == 0, $urandom_range(5) == 0);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
